// File: rtl/fp_exec_sequencer_if.sv
// Issue, FP-unit, writeback and CSR signals of the FP execution sequencer.
// The slave modport is the sequencer's view; master is the surrounding pipeline.
interface fp_exec_sequencer_if #(
  parameter int unsigned EXPONENT_WIDTH = 8,
  parameter int unsigned FRACTION_WIDTH = 23,
  parameter int unsigned FP_WIDTH       = 1 + EXPONENT_WIDTH + FRACTION_WIDTH
);
  localparam int unsigned WORD_WIDTH    = 32;
  localparam int unsigned FLAGS_WIDTH   = 5;
  localparam int unsigned UNIT_WIDTH    = 3;
  localparam int unsigned COMMAND_WIDTH = 4;
  localparam int unsigned RM_WIDTH      = 3;
  localparam int unsigned REG_WIDTH     = 5;

  logic                     reqValid;
  logic                     reqReady;
  logic [UNIT_WIDTH-1:0]    reqUnit;
  logic [COMMAND_WIDTH-1:0] reqCommand;
  logic [RM_WIDTH-1:0]      reqRm;
  logic [WORD_WIDTH-1:0]    reqIntSrc1;
  logic [WORD_WIDTH-1:0]    reqIntSrc2;
  logic [FP_WIDTH-1:0]      reqFpSrc1;
  logic [FP_WIDTH-1:0]      reqFpSrc2;
  logic [FP_WIDTH-1:0]      reqFpSrc3;
  logic [REG_WIDTH-1:0]     reqRd;
  logic [RM_WIDTH-1:0]      frm;
  logic                     flush;

  logic                     fuEnable;
  logic                     fuFlush;
  logic [UNIT_WIDTH-1:0]    fuUnit;
  logic [COMMAND_WIDTH-1:0] fuCommand;
  logic [RM_WIDTH-1:0]      fuRoundingMode;
  logic [WORD_WIDTH-1:0]    fuIntSrc1;
  logic [WORD_WIDTH-1:0]    fuIntSrc2;
  logic [FP_WIDTH-1:0]      fuFpSrc1;
  logic [FP_WIDTH-1:0]      fuFpSrc2;
  logic [FP_WIDTH-1:0]      fuFpSrc3;
  logic                     fuDone;
  logic                     fuWriteFlags;
  logic [FLAGS_WIDTH-1:0]   fuFlags;
  logic [WORD_WIDTH-1:0]    fuIntResult;
  logic [FP_WIDTH-1:0]      fuFpResult;

  logic                     wbValid;
  logic                     wbReady;
  logic [REG_WIDTH-1:0]     wbRd;
  logic [WORD_WIDTH-1:0]    wbIntResult;
  logic [FP_WIDTH-1:0]      wbFpResult;
  logic                     wbIllegal;

  logic                     csrWrite;
  logic [FLAGS_WIDTH-1:0]   csrWriteValue;
  logic [FLAGS_WIDTH-1:0]   fflags;

  modport slave (
    input  reqValid, reqUnit, reqCommand, reqRm, reqIntSrc1, reqIntSrc2,
           reqFpSrc1, reqFpSrc2, reqFpSrc3, reqRd, frm, flush,
           fuDone, fuWriteFlags, fuFlags, fuIntResult, fuFpResult,
           wbReady, csrWrite, csrWriteValue,
    output reqReady, fuEnable, fuFlush, fuUnit, fuCommand, fuRoundingMode,
           fuIntSrc1, fuIntSrc2, fuFpSrc1, fuFpSrc2, fuFpSrc3,
           wbValid, wbRd, wbIntResult, wbFpResult, wbIllegal, fflags
  );

  modport master (
    output reqValid, reqUnit, reqCommand, reqRm, reqIntSrc1, reqIntSrc2,
           reqFpSrc1, reqFpSrc2, reqFpSrc3, reqRd, frm, flush,
           fuDone, fuWriteFlags, fuFlags, fuIntResult, fuFpResult,
           wbReady, csrWrite, csrWriteValue,
    input  reqReady, fuEnable, fuFlush, fuUnit, fuCommand, fuRoundingMode,
           fuIntSrc1, fuIntSrc2, fuFpSrc1, fuFpSrc2, fuFpSrc3,
           wbValid, wbRd, wbIntResult, wbFpResult, wbIllegal, fflags
  );
endinterface

// File: rtl/fp_exec_sequencer.sv
// Issue-side sequencer for the FP execution unit: latches one operation, runs it
// on the FP unit, hands the result to writeback and accumulates sticky fflags.
module fp_exec_sequencer #(
  parameter int unsigned EXPONENT_WIDTH = 8,
  parameter int unsigned FRACTION_WIDTH = 23,
  parameter int unsigned FP_WIDTH       = 1 + EXPONENT_WIDTH + FRACTION_WIDTH
) (
  input logic                clk,
  input logic                rst,
  fp_exec_sequencer_if.slave bus
);
  localparam int unsigned WORD_WIDTH    = 32;
  localparam int unsigned FLAGS_WIDTH   = 5;
  localparam int unsigned UNIT_WIDTH    = 3;
  localparam int unsigned COMMAND_WIDTH = 4;
  localparam int unsigned RM_WIDTH      = 3;
  localparam int unsigned REG_WIDTH     = 5;
  localparam logic [RM_WIDTH-1:0] RM_DYN = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

  state_e                   state_q;
  logic                     req_ready_q;
  logic                     fu_enable_q;
  logic                     wb_valid_q;
  logic [UNIT_WIDTH-1:0]    unit_q;
  logic [COMMAND_WIDTH-1:0] command_q;
  logic [RM_WIDTH-1:0]      rm_q;
  logic [WORD_WIDTH-1:0]    int_src1_q;
  logic [WORD_WIDTH-1:0]    int_src2_q;
  logic [FP_WIDTH-1:0]      fp_src1_q;
  logic [FP_WIDTH-1:0]      fp_src2_q;
  logic [FP_WIDTH-1:0]      fp_src3_q;
  logic [REG_WIDTH-1:0]     rd_q;
  logic [WORD_WIDTH-1:0]    int_result_q;
  logic [FP_WIDTH-1:0]      fp_result_q;
  logic                     write_flags_q;
  logic [FLAGS_WIDTH-1:0]   flags_q;
  logic                     illegal_q;
  logic [FLAGS_WIDTH-1:0]   fflags_q;

  logic [RM_WIDTH-1:0]      eff_rm_c;
  logic                     illegal_rm_c;
  logic                     commit_c;
  logic [FLAGS_WIDTH-1:0]   fflags_next_c;

  // Rounding-mode resolution and the sticky-flag update shared by commit and CSR write.
  always_comb begin
    eff_rm_c      = (bus.reqRm == RM_DYN) ? bus.frm : bus.reqRm;
    illegal_rm_c  = (eff_rm_c == 3'd5) || (eff_rm_c == 3'd6);
    commit_c      = (state_q == WB) && bus.wbReady && !bus.flush;
    fflags_next_c = bus.csrWrite ? bus.csrWriteValue : fflags_q;
    if (commit_c && write_flags_q && !illegal_q) begin
      fflags_next_c = fflags_next_c | flags_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      fu_enable_q   <= 1'b0;
      wb_valid_q    <= 1'b0;
      unit_q        <= '0;
      command_q     <= '0;
      rm_q          <= '0;
      int_src1_q    <= '0;
      int_src2_q    <= '0;
      fp_src1_q     <= '0;
      fp_src2_q     <= '0;
      fp_src3_q     <= '0;
      rd_q          <= '0;
      int_result_q  <= '0;
      fp_result_q   <= '0;
      write_flags_q <= 1'b0;
      flags_q       <= '0;
      illegal_q     <= 1'b0;
      fflags_q      <= '0;
    end else begin
      fflags_q <= fflags_next_c;
      if (bus.flush) begin
        // Flush wins over any same-cycle accept or commit and drops all held data.
        state_q       <= IDLE;
        req_ready_q   <= 1'b1;
        fu_enable_q   <= 1'b0;
        wb_valid_q    <= 1'b0;
        unit_q        <= '0;
        command_q     <= '0;
        rm_q          <= '0;
        int_src1_q    <= '0;
        int_src2_q    <= '0;
        fp_src1_q     <= '0;
        fp_src2_q     <= '0;
        fp_src3_q     <= '0;
        rd_q          <= '0;
        int_result_q  <= '0;
        fp_result_q   <= '0;
        write_flags_q <= 1'b0;
        flags_q       <= '0;
        illegal_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.reqValid) begin
              unit_q        <= bus.reqUnit;
              command_q     <= bus.reqCommand;
              rm_q          <= eff_rm_c;
              int_src1_q    <= bus.reqIntSrc1;
              int_src2_q    <= bus.reqIntSrc2;
              fp_src1_q     <= bus.reqFpSrc1;
              fp_src2_q     <= bus.reqFpSrc2;
              fp_src3_q     <= bus.reqFpSrc3;
              rd_q          <= bus.reqRd;
              int_result_q  <= '0;
              fp_result_q   <= '0;
              write_flags_q <= 1'b0;
              flags_q       <= '0;
              illegal_q     <= illegal_rm_c;
              req_ready_q   <= 1'b0;
              // Illegal rounding modes bypass the FP unit with zero results.
              if (illegal_rm_c) begin
                state_q    <= WB;
                wb_valid_q <= 1'b1;
              end else begin
                state_q     <= EXEC;
                fu_enable_q <= 1'b1;
              end
            end
          end
          EXEC: begin
            if (bus.fuDone) begin
              int_result_q  <= bus.fuIntResult;
              fp_result_q   <= bus.fuFpResult;
              write_flags_q <= bus.fuWriteFlags;
              flags_q       <= bus.fuFlags;
              state_q       <= WB;
              fu_enable_q   <= 1'b0;
              wb_valid_q    <= 1'b1;
            end
          end
          WB: begin
            if (bus.wbReady) begin
              state_q     <= IDLE;
              wb_valid_q  <= 1'b0;
              req_ready_q <= 1'b1;
            end
          end
          default: begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            fu_enable_q <= 1'b0;
            wb_valid_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.reqReady       = req_ready_q;
  assign bus.fuEnable       = fu_enable_q;
  assign bus.fuFlush        = bus.flush;
  assign bus.fuUnit         = unit_q;
  assign bus.fuCommand      = command_q;
  assign bus.fuRoundingMode = rm_q;
  assign bus.fuIntSrc1      = int_src1_q;
  assign bus.fuIntSrc2      = int_src2_q;
  assign bus.fuFpSrc1       = fp_src1_q;
  assign bus.fuFpSrc2       = fp_src2_q;
  assign bus.fuFpSrc3       = fp_src3_q;
  assign bus.wbValid        = wb_valid_q;
  assign bus.wbRd           = rd_q;
  assign bus.wbIntResult    = int_result_q;
  assign bus.wbFpResult     = fp_result_q;
  assign bus.wbIllegal      = illegal_q;
  assign bus.fflags         = fflags_q;
endmodule

// File: tb/tb_fp_exec_sequencer.sv
// Bench for fp_exec_sequencer: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_fp_exec_sequencer;
  localparam logic [2:0] UNIT_FMA  = 3'd1;
  localparam logic [2:0] UNIT_SQRT = 3'd3;
  localparam logic [2:0] UNIT_FMV  = 3'd4;
  localparam int S_FREE = 0, S_BUSY = 1, S_RESULT = 2;

  typedef struct packed {
    logic [2:0]  unit;
    logic [3:0]  cmd;
    logic [2:0]  rm;
    logic [31:0] i1, i2, f1, f2, f3;
    logic [4:0]  rd;
    logic        ill;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_exec_sequencer_if #(.EXPONENT_WIDTH(8), .FRACTION_WIDTH(23)) bus();
  fp_exec_sequencer #(.EXPONENT_WIDTH(8), .FRACTION_WIDTH(23)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;
  logic junk_done = 1'b0;
  int next_lat = 1;

  // Model: one operation slot that is free, executing, or holding a result.
  op_t m_op;
  int m_stage = S_FREE;
  int m_lat = 1, m_cnt = 0;
  logic [31:0] m_ires, m_fres;
  logic m_wf;
  logic [4:0] m_flags;
  logic [4:0] m_fflags = 5'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stage = S_FREE; m_fflags = 5'd0; m_op = '0;
    m_ires = '0; m_fres = '0; m_wf = 1'b0; m_flags = '0;
  endtask

  task automatic model_step();
    logic [2:0] rm;
    if (m_stage == S_RESULT && bus.wbReady && !bus.flush)
      m_fflags = (bus.csrWrite ? bus.csrWriteValue : m_fflags) | ((m_wf && !m_op.ill) ? m_flags : 5'd0);
    else if (bus.csrWrite)
      m_fflags = bus.csrWriteValue;
    if (bus.flush) begin
      m_stage = S_FREE;
    end else if (m_stage == S_FREE) begin
      if (bus.reqValid) begin
        rm = (bus.reqRm == 3'b111) ? bus.frm : bus.reqRm;
        m_op = '{unit: bus.reqUnit, cmd: bus.reqCommand, rm: rm, i1: bus.reqIntSrc1, i2: bus.reqIntSrc2,
                 f1: bus.reqFpSrc1, f2: bus.reqFpSrc2, f3: bus.reqFpSrc3, rd: bus.reqRd,
                 ill: (rm == 3'd5 || rm == 3'd6)};
        m_ires = '0; m_fres = '0; m_wf = 1'b0; m_flags = '0;
        m_lat = next_lat; m_cnt = 0;
        m_stage = m_op.ill ? S_RESULT : S_BUSY;
      end
    end else if (m_stage == S_BUSY) begin
      if (bus.fuDone) begin
        m_ires = bus.fuIntResult; m_fres = bus.fuFpResult;
        m_wf = bus.fuWriteFlags; m_flags = bus.fuFlags;
        m_stage = S_RESULT;
      end else begin
        m_cnt++;
      end
    end else if (bus.wbReady) begin
      m_stage = S_FREE;
    end
  endtask

  // One clock: advance the model on the edge, then play the FP unit for the new cycle.
  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
    if (m_stage == S_BUSY) bus.fuDone = (m_cnt == m_lat - 1);
    else bus.fuDone = junk_done ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en && rst) begin
      chk("reqReady", 64'(bus.reqReady), 64'(m_stage == S_FREE));
      chk("fuEnable", 64'(bus.fuEnable), 64'(m_stage == S_BUSY));
      chk("wbValid", 64'(bus.wbValid), 64'(m_stage == S_RESULT));
      chk("fflags", 64'(bus.fflags), 64'(m_fflags));
      chk("fuFlush", 64'(bus.fuFlush), 64'(bus.flush));
      if (m_stage == S_BUSY) begin
        chk("fuUnit", 64'(bus.fuUnit), 64'(m_op.unit));
        chk("fuCommand", 64'(bus.fuCommand), 64'(m_op.cmd));
        chk("fuRoundingMode", 64'(bus.fuRoundingMode), 64'(m_op.rm));
        chk("fuIntSrcs", {bus.fuIntSrc1, bus.fuIntSrc2}, {m_op.i1, m_op.i2});
        chk("fuFpSrc12", {bus.fuFpSrc1, bus.fuFpSrc2}, {m_op.f1, m_op.f2});
        chk("fuFpSrc3", 64'(bus.fuFpSrc3), 64'(m_op.f3));
      end
      if (m_stage == S_RESULT) begin
        chk("wbRd", 64'(bus.wbRd), 64'(m_op.rd));
        chk("wbIllegal", 64'(bus.wbIllegal), 64'(m_op.ill));
        chk("wbIntResult", 64'(bus.wbIntResult), 64'(m_ires));
        chk("wbFpResult", 64'(bus.wbFpResult), 64'(m_fres));
      end
    end
  end

  task automatic issue(input logic [2:0] u, input logic [2:0] rm, input logic [2:0] fr,
                       input logic [31:0] f1, input int lat);
    bus.reqValid = 1'b1; bus.reqUnit = u; bus.reqCommand = 4'd2; bus.reqRm = rm; bus.frm = fr;
    bus.reqFpSrc1 = f1; bus.reqFpSrc2 = 32'h40000000; bus.reqFpSrc3 = 32'h40400000;
    bus.reqIntSrc1 = 32'h11; bus.reqIntSrc2 = 32'h22; bus.reqRd = 5'd7; next_lat = lat;
    tick();
    bus.reqValid = 1'b0;
  endtask

  initial begin
    int en_cycles, wb_cycle;
    rst = 1'b0;
    bus.reqValid = 0; bus.reqUnit = 0; bus.reqCommand = 0; bus.reqRm = 0;
    bus.reqIntSrc1 = 0; bus.reqIntSrc2 = 0; bus.reqFpSrc1 = 0; bus.reqFpSrc2 = 0; bus.reqFpSrc3 = 0;
    bus.reqRd = 0; bus.frm = 0; bus.flush = 0; bus.fuDone = 0; bus.fuWriteFlags = 0; bus.fuFlags = 0;
    bus.fuIntResult = 0; bus.fuFpResult = 0; bus.wbReady = 0; bus.csrWrite = 0; bus.csrWriteValue = 0;
    model_reset();
    tick(); tick();
    chk("reset reqReady", 64'(bus.reqReady), 64'd1);
    chk("reset outputs", {bus.fuEnable, bus.wbValid, bus.wbIllegal, bus.fflags}, 64'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    tick();

    // FMV.X.W: single-cycle unit, result passes through, no flags
    issue(UNIT_FMV, 3'd0, 3'd0, 32'h3F800000, 1);
    bus.fuIntResult = 32'h3F800000; bus.fuWriteFlags = 1'b0;
    chk("fmv enable", 64'(bus.fuEnable), 64'd1);
    tick();
    chk("fmv enable one cycle", 64'(bus.fuEnable), 64'd0);
    chk("fmv wbIntResult", 64'(bus.wbIntResult), 64'h3F800000);
    bus.wbReady = 1'b1; tick(); bus.wbReady = 1'b0;
    chk("fmv fflags", 64'(bus.fflags), 64'd0);

    // MulAdd with writeback stalled for 3 cycles
    issue(UNIT_FMA, 3'd0, 3'd0, 32'h3F800000, 1);
    bus.fuFlags = 5'b00001; bus.fuWriteFlags = 1'b1; bus.fuFpResult = 32'h40A00000;
    tick();
    bus.fuFpResult = 32'h0; bus.fuFlags = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      chk("fma stall wbValid", 64'(bus.wbValid), 64'd1);
      chk("fma stall wbFpResult", 64'(bus.wbFpResult), 64'h40A00000);
      chk("fma stall fflags", 64'(bus.fflags), 64'd0);
      tick();
    end
    bus.wbReady = 1'b1; tick(); bus.wbReady = 1'b0;
    chk("fma fflags", 64'(bus.fflags), 64'h01);
    issue(UNIT_FMA, 3'd0, 3'd0, 32'h3F800000, 1);
    bus.fuFlags = 5'b10000;
    tick();
    bus.wbReady = 1'b1; tick(); bus.wbReady = 1'b0;
    chk("second fflags", 64'(bus.fflags), 64'h11);
    bus.fuWriteFlags = 1'b0;

    // Sqrt with a 12-cycle latency
    issue(UNIT_SQRT, 3'd0, 3'd0, 32'h41100000, 12);
    en_cycles = 0; wb_cycle = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.wbValid) begin wb_cycle = c; break; end
      if (bus.fuEnable) en_cycles++;
      chk("sqrt operand hold", 64'(bus.fuFpSrc1), 64'h41100000);
      tick();
    end
    chk("sqrt enable cycles", 64'(en_cycles), 64'd12);
    chk("sqrt wbValid cycle", 64'(wb_cycle), 64'd13);
    bus.wbReady = 1'b1; tick(); bus.wbReady = 1'b0;

    // Dynamic rounding mode, legal then illegal
    issue(UNIT_FMA, 3'b111, 3'b010, 32'h3F800000, 1);
    chk("dyn rm", 64'(bus.fuRoundingMode), 64'd2);
    tick();
    bus.wbReady = 1'b1; tick(); bus.wbReady = 1'b0;
    issue(UNIT_FMA, 3'b111, 3'b101, 32'h3F800000, 1);
    chk("illegal no exec", {bus.fuEnable, bus.wbValid, bus.wbIllegal}, 64'b011);
    chk("illegal zero result", 64'(bus.wbIntResult), 64'd0);
    bus.fuWriteFlags = 1'b1; bus.fuFlags = 5'b01110;
    bus.wbReady = 1'b1; tick(); bus.wbReady = 1'b0;
    chk("illegal fflags", 64'(bus.fflags), 64'h11);

    // Flush in the middle of a sqrt
    issue(UNIT_SQRT, 3'd0, 3'd0, 32'h41100000, 12);
    tick(); tick();
    bus.flush = 1'b1;
    #1 chk("fuFlush", 64'(bus.fuFlush), 64'd1);
    tick();
    bus.flush = 1'b0;
    chk("flush idle", {bus.reqReady, bus.fuEnable, bus.wbValid}, 64'b100);
    chk("flush fflags", 64'(bus.fflags), 64'h11);
    issue(UNIT_FMV, 3'd0, 3'd0, 32'h3F800000, 1);
    chk("post flush accept", 64'(bus.fuEnable), 64'd1);
    bus.fuFlags = 5'b00001; bus.fuWriteFlags = 1'b1;
    tick();

    // CSR write in the same cycle as a commit
    bus.wbReady = 1'b1; bus.csrWrite = 1'b1; bus.csrWriteValue = 5'b00100;
    tick();
    bus.wbReady = 1'b0; bus.csrWrite = 1'b0;
    chk("csr plus commit", 64'(bus.fflags), 64'h05);

    // Asynchronous reset while a sqrt is executing
    issue(UNIT_SQRT, 3'd0, 3'd0, 32'h41100000, 12);
    tick();
    chk_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async reset ctl", {bus.reqReady, bus.fuEnable, bus.wbValid, bus.wbIllegal}, 64'b1000);
    chk("async reset data", {bus.fuFpSrc1, bus.wbIntResult}, 64'd0);
    chk("async reset fflags", 64'(bus.fflags), 64'd0);
    model_reset();
    tick();
    rst = 1'b1;
    chk_en = 1'b1;

    // Randomized traffic
    junk_done = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      bus.reqValid = 1'($urandom_range(0, 1));
      bus.reqUnit = 3'($urandom); bus.reqCommand = 4'($urandom); bus.reqRm = 3'($urandom);
      bus.frm = 3'($urandom); bus.reqRd = 5'($urandom);
      bus.reqIntSrc1 = $urandom; bus.reqIntSrc2 = $urandom;
      bus.reqFpSrc1 = $urandom; bus.reqFpSrc2 = $urandom; bus.reqFpSrc3 = $urandom;
      bus.flush = ($urandom_range(0, 19) == 0);
      bus.wbReady = ($urandom_range(0, 2) != 0);
      bus.csrWrite = ($urandom_range(0, 7) == 0);
      bus.csrWriteValue = 5'($urandom);
      bus.fuWriteFlags = 1'($urandom_range(0, 1)); bus.fuFlags = 5'($urandom);
      bus.fuIntResult = $urandom; bus.fuFpResult = $urandom;
      next_lat = $urandom_range(1, 4);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_exec_sequencer.md
# fp_exec_sequencer

Issue-side controller for the floating-point execution unit. It accepts one FP operation per valid/ready handshake, latches its operands and resolves the rounding mode, drives the FP unit's `enable`/`flush`/`unit`/`command` inputs, waits for `done`, and presents the result to writeback through a second valid/ready handshake. It owns the sticky `fflags` accumulator, which the CSR path reads and writes.

## Interface
Parameters:
- `EXPONENT_WIDTH`, default 8: FP exponent width.
- `FRACTION_WIDTH`, default 23: FP fraction width.
- `FP_WIDTH`, default 1+EXPONENT_WIDTH+FRACTION_WIDTH: FP register width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `reqValid`  in  1  upstream operation valid.
- `reqReady`  out  1  sequencer can accept an operation.
- `reqUnit`  in  FpUnitType  target sub-unit.
- `reqCommand`  in  FpUnitCommand  sub-unit command.
- `reqRm`  in  3  instruction rounding mode; 3'b111 = DYN.
- `reqIntSrc1`, `reqIntSrc2`  in  word_t  integer operands.
- `reqFpSrc1`, `reqFpSrc2`, `reqFpSrc3`  in  FP_WIDTH  FP operands.
- `reqRd`  in  5  destination register index.
- `frm`  in  3  CSR dynamic rounding mode.
- `flush`  in  1  pipeline flush.
- `fuEnable`  out  1  to FP unit `enable`.
- `fuFlush`  out  1  to FP unit `flush`.
- `fuUnit`  out  FpUnitType  to FP unit `unit`.
- `fuCommand`  out  FpUnitCommand  to FP unit `command`.
- `fuRoundingMode`  out  3  resolved rounding mode.
- `fuIntSrc1`, `fuIntSrc2`  out  word_t  latched integer operands.
- `fuFpSrc1`, `fuFpSrc2`, `fuFpSrc3`  out  FP_WIDTH  latched FP operands.
- `fuDone`, `fuWriteFlags`  in  1  from FP unit.
- `fuFlags`  in  fflags_t  from FP unit.
- `fuIntResult`  in  word_t  from FP unit.
- `fuFpResult`  in  FP_WIDTH  from FP unit.
- `wbValid`  out  1  result available.
- `wbReady`  in  1  writeback accepts the result.
- `wbRd`  out  5  destination register.
- `wbIntResult`  out  word_t  captured integer result.
- `wbFpResult`  out  FP_WIDTH  captured FP result.
- `wbIllegal`  out  1  operation rejected for an illegal rounding mode.
- `csrWrite`  in  1  overwrite `fflags`.
- `csrWriteValue`  in  fflags_t  value to write.
- `fflags`  out  fflags_t  sticky accumulated exception flags.

## Operation
- States:
  - IDLE: `reqReady`=1. On `reqValid`, latch all req fields and go to EXEC, or to WB with the illegal bit set if the rounding mode is illegal.
  - EXEC: `fuEnable`=1, fu* outputs driven from the latches. When `fuDone`=1, capture both results, `fuWriteFlags` and `fuFlags`, then go to WB.
  - WB: `wbValid`=1. When `wbReady`=1, commit and go to IDLE.
- Rounding-mode resolution:
  - Effective rm = `frm` when `reqRm`==3'b111, otherwise `reqRm`.
  - Effective rm of 5 or 6 is illegal (including DYN with `frm` of 5 or 6). An illegal operation never enters EXEC, sets `wbIllegal`=1, and presents zero results.
- Commit on the WB handshake:
  - `fflags` <= (`csrWrite` ? `csrWriteValue` : `fflags`) | (captured writeFlags && !illegal ? captured flags : 0).
  - `csrWrite` outside a commit sets `fflags` to `csrWriteValue`.
- Flush:
  - `fuFlush` = `flush`, passed through combinationally.
  - `flush` in any state forces IDLE on the next edge and discards latched and captured data.
  - A flushed operation never updates `fflags`.
  - `flush` overrides a same-cycle `reqValid` acceptance and a same-cycle `wbReady` commit.
  - `csrWrite` in the flush cycle still takes effect.
- Latches are held stable for the whole of EXEC. Multi-cycle units such as sqrt see `enable` held high continuously until `done`.

## Timing
- Reset (`rst` low): state IDLE, every latch and capture register 0, `fflags`=0, `wbValid`=0, `fuEnable`=0, `wbIllegal`=0, `reqReady`=1.
- Single-cycle unit, accepted at edge N: EXEC in cycle N+1 (`fuDone`=1), WB in cycle N+2. With `wbReady` high, back in IDLE at N+3. Peak throughput is 1 operation per 3 cycles.
- Sqrt taking k cycles to `done`: EXEC lasts k cycles. `wbValid` rises on the cycle after the `fuDone` cycle.
- Illegal rm: IDLE → WB directly, so `wbValid` asserts in cycle N+1.
- `wbValid` and its data stay stable until the handshake or a flush.

## Test plan
- Reset release, then FMV.X.W with fpSrc1=32'h3F800000 → `fuEnable` high for exactly 1 cycle, `wbIntResult`=32'h3F800000, `fflags` stays 0.
- MulAdd with `fuFlags`=5'b00001, `wbReady` held low 3 cycles → `wbValid` and data stable for those cycles; `fflags`=5'b00001 only after the handshake. A second op with flags 5'b10000 → `fflags`=5'b10001.
- Sqrt with the model asserting done after 12 cycles → `fuEnable` high for 12 consecutive cycles, latched operands unchanged throughout, `wbValid` on cycle 13.
- `reqRm`=3'b111 with `frm`=3'b010 → `fuRoundingMode`=3'b010. `frm`=3'b101 → no EXEC, `wbIllegal`=1, `fflags` unchanged.
- `flush` during the EXEC of a sqrt → `fuFlush`=1 that cycle, IDLE next edge, no `wbValid`, `fflags` unchanged, next request accepted.
- `csrWrite` with value 5'b00100 in the same cycle as a commit with flags 5'b00001 → `fflags`=5'b00101. Async `rst` low mid-EXEC → all outputs return to reset values immediately.
